// File: rtl/systolic_pkg.sv
// Shared types, default sizes and accumulator range helper for the systolic array.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 16;
    localparam int DEF_KW         = 8;

    // Bring a wide signed sum back into the signed acc_w range: either clamp
    // to the representable limits or keep the low acc_w bits (sign-extended).
    function automatic logic signed [63:0] sat_wrap(
        input logic signed [63:0] val,
        input int                 acc_w,
        input logic               sat
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi = (64'sd1 <<< (acc_w - 32'sd1)) - 64'sd1;
        lo = -(64'sd1 <<< (acc_w - 32'sd1));
        if (sat) begin
            if (val > hi) begin
                res = hi;
            end else if (val < lo) begin
                res = lo;
            end else begin
                res = val;
            end
        end else begin
            res = (val <<< (32'sd64 - acc_w)) >>> (32'sd64 - acc_w);
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mac.sv
// One output-stationary processing element: passes a right and b down,
// accumulates a*b on every array step.
module pe_mac
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SATURATE   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_en,
    input  logic                         i_clr,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH-1:0] o_a,
    output logic signed [DATA_WIDTH-1:0] o_b,
    output logic signed [ACC_WIDTH-1:0]  o_acc
);

    logic signed [DATA_WIDTH-1:0]   r_a;
    logic signed [DATA_WIDTH-1:0]   r_b;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH:0]      w_prod_ext;
    logic signed [63:0]             w_sum64;
    logic signed [63:0]             w_next64;
    logic signed [ACC_WIDTH-1:0]    w_acc_next;
    logic                           w_unused_hi;

    assign w_prod = i_a * i_b;

    // Fit the full-precision product to one bit more than the accumulator.
    generate
        if (2 * DATA_WIDTH >= ACC_WIDTH + 1) begin : g_prod_trunc
            assign w_prod_ext = w_prod[ACC_WIDTH:0];
        end else begin : g_prod_sext
            assign w_prod_ext = {{(ACC_WIDTH + 1 - 2 * DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
        end
    endgenerate

    // The add is done wide so that clamping sees the true sum.
    assign w_sum64 = {{(63 - ACC_WIDTH){w_prod_ext[ACC_WIDTH]}}, w_prod_ext}
                   + {{(64 - ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
    assign w_next64    = sat_wrap(w_sum64, ACC_WIDTH, SATURATE != 0);
    assign w_acc_next  = w_next64[ACC_WIDTH-1:0];
    assign w_unused_hi = ^w_next64[63:ACC_WIDTH];

    // Pass registers and accumulator: cleared at job start, advance only on steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_en) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= w_acc_next;
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/systolic_array_nxm.sv
// ROWS x COLS output-stationary MAC array with input skewing, a
// clear/feed/drain/readout controller and valid/ready on both sides.
module systolic_array_nxm
    import systolic_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int KW         = DEF_KW,
    parameter int SATURATE   = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [KW-1:0]                           k_len,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]              a_vec,
    input  logic [COLS*DATA_WIDTH-1:0]              b_vec,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [COLS*ACC_WIDTH-1:0]               out_row,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_idx,
    output logic                                    busy,
    output logic                                    done
);

    localparam int IDXW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DRAIN_CYC = ROWS + COLS - 2;
    localparam int DCW       = $clog2(ROWS + COLS);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [KW-1:0]   r_kcnt;
    logic [KW-1:0]   w_kcnt_nxt;
    logic [DCW-1:0]  r_dcnt;
    logic [DCW-1:0]  w_dcnt_nxt;
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] w_idx_nxt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_beat;
    logic            w_step;
    logic            w_clr;

    logic signed [DATA_WIDTH-1:0] w_a_lane [ROWS];
    logic signed [DATA_WIDTH-1:0] w_b_lane [COLS];
    logic signed [DATA_WIDTH-1:0] w_a_skew [ROWS];
    logic signed [DATA_WIDTH-1:0] w_b_skew [COLS];
    logic signed [DATA_WIDTH-1:0] w_a_in   [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] w_b_in   [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] w_a_out  [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] w_b_out  [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]  w_acc    [ROWS][COLS];
    logic [COLS*ACC_WIDTH-1:0]    w_out_row;

    // A beat is consumed only when offered while the array is ready in FEED;
    // during DRAIN the array steps every cycle on injected zeros.
    assign w_beat = (r_state == ST_FEED) & in_valid & r_in_ready;
    assign w_step = w_beat | (r_state == ST_DRAIN);
    assign w_clr  = (r_state == ST_IDLE) & start;

    // Next-state, counters and done pulse for the clear/feed/drain/readout sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_kcnt_nxt  = r_kcnt;
        w_dcnt_nxt  = r_dcnt;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_kcnt_nxt = k_len;
                    w_dcnt_nxt = {DCW{1'b0}};
                    w_idx_nxt  = {IDXW{1'b0}};
                    if (k_len == {KW{1'b0}}) begin
                        w_state_nxt = ST_OUT;
                    end else begin
                        w_state_nxt = ST_FEED;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (w_beat) begin
                    w_kcnt_nxt = r_kcnt - KW'(1);
                    if (r_kcnt == KW'(1)) begin
                        if (DRAIN_CYC == 0) begin
                            w_state_nxt = ST_OUT;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end else begin
                        w_state_nxt = ST_FEED;
                    end
                end else begin
                    w_state_nxt = ST_FEED;
                end
            end
            ST_DRAIN: begin
                w_dcnt_nxt = r_dcnt + DCW'(1);
                if (r_dcnt == DCW'(DRAIN_CYC - 1)) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (r_out_valid & out_ready) begin
                    if (r_idx == IDXW'(ROWS - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = {IDXW{1'b0}};
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + IDXW'(1);
                    end
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller registers; handshake/status outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_kcnt      <= '0;
            r_dcnt      <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_kcnt      <= w_kcnt_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_idx       <= w_idx_nxt;
            r_in_ready  <= (w_state_nxt == ST_FEED);
            r_out_valid <= (w_state_nxt == ST_OUT);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    // Row i of A is delayed by i steps so that PE(i,j) meets beat k at step k+i+j.
    generate
        for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
            assign w_a_lane[i] = w_beat ? $signed(a_vec[i*DATA_WIDTH +: DATA_WIDTH]) : '0;
            if (i == 0) begin : g_direct
                assign w_a_skew[i] = w_a_lane[i];
            end else begin : g_chain
                logic signed [DATA_WIDTH-1:0] r_sk [i];
                // Row-i skew shift register, advancing on array steps.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int d = 0; d < i; d++) r_sk[d] <= '0;
                    end else if (w_clr) begin
                        for (int d = 0; d < i; d++) r_sk[d] <= '0;
                    end else if (w_step) begin
                        r_sk[0] <= w_a_lane[i];
                        for (int d = 1; d < i; d++) r_sk[d] <= r_sk[d-1];
                    end
                end
                assign w_a_skew[i] = r_sk[i-1];
            end
        end

        for (genvar j = 0; j < COLS; j++) begin : g_b_skew
            assign w_b_lane[j] = w_beat ? $signed(b_vec[j*DATA_WIDTH +: DATA_WIDTH]) : '0;
            if (j == 0) begin : g_direct
                assign w_b_skew[j] = w_b_lane[j];
            end else begin : g_chain
                logic signed [DATA_WIDTH-1:0] r_sk [j];
                // Column-j skew shift register, advancing on array steps.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int d = 0; d < j; d++) r_sk[d] <= '0;
                    end else if (w_clr) begin
                        for (int d = 0; d < j; d++) r_sk[d] <= '0;
                    end else if (w_step) begin
                        r_sk[0] <= w_b_lane[j];
                        for (int d = 1; d < j; d++) r_sk[d] <= r_sk[d-1];
                    end
                end
                assign w_b_skew[j] = r_sk[j-1];
            end
        end

        for (genvar i = 0; i < ROWS; i++) begin : g_row
            for (genvar j = 0; j < COLS; j++) begin : g_col
                if (j == 0) begin : g_a_edge
                    assign w_a_in[i][j] = w_a_skew[i];
                end else begin : g_a_link
                    assign w_a_in[i][j] = w_a_out[i][j-1];
                end
                if (i == 0) begin : g_b_edge
                    assign w_b_in[i][j] = w_b_skew[j];
                end else begin : g_b_link
                    assign w_b_in[i][j] = w_b_out[i-1][j];
                end
                pe_mac #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .ACC_WIDTH  (ACC_WIDTH),
                    .SATURATE   (SATURATE)
                ) u_pe (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .i_en  (w_step),
                    .i_clr (w_clr),
                    .i_a   (w_a_in[i][j]),
                    .i_b   (w_b_in[i][j]),
                    .o_a   (w_a_out[i][j]),
                    .o_b   (w_b_out[i][j]),
                    .o_acc (w_acc[i][j])
                );
            end
        end
    endgenerate

    // Present the selected result row while readout is active, zero otherwise.
    always_comb begin
        w_out_row = '0;
        if (r_out_valid) begin
            for (int j = 0; j < COLS; j++) begin
                w_out_row[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_idx][j];
            end
        end else begin
            w_out_row = '0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_row   = w_out_row;
    assign out_idx   = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_systolic_array_nxm.sv
// Self-checking bench: a wrapping and a saturating array driven in lockstep,
// compared against a plain matrix-product reference model.
module tb_systolic_array_nxm;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int KW   = 8;
    localparam int KMAX = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 in_valid;
    logic [ROWS*DW-1:0]   a_vec;
    logic [COLS*DW-1:0]   b_vec;
    logic                 out_ready;

    logic                 in_ready0, in_ready1;
    logic                 out_valid0, out_valid1;
    logic [COLS*AW-1:0]   out_row0, out_row1;
    logic [1:0]           out_idx0, out_idx1;
    logic                 busy0, busy1;
    logic                 done0, done1;

    int n_checks = 0;
    int n_err    = 0;
    int A_m [ROWS][KMAX];
    int B_m [KMAX][COLS];

    always #5 clk = ~clk;

    systolic_array_nxm #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KW(KW), .SATURATE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready0), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid0), .out_ready(out_ready), .out_row(out_row0),
        .out_idx(out_idx0), .busy(busy0), .done(done0)
    );

    systolic_array_nxm #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KW(KW), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready1), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid1), .out_ready(out_ready), .out_row(out_row1),
        .out_idx(out_idx1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], clamped after every add when sat.
    function automatic logic [63:0] exp_row(input int i, input int k, input bit sat);
        logic [63:0] r;
        int          acc;
        r = 64'd0;
        for (int j = 0; j < COLS; j++) begin
            acc = 0;
            for (int kk = 0; kk < k; kk++) begin
                acc = acc + A_m[i][kk] * B_m[kk][j];
                if (sat) begin
                    if (acc > 32767) acc = 32767;
                    else if (acc < -32768) acc = -32768;
                end
            end
            r[j*AW +: AW] = 16'(acc);
        end
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < KMAX; k++) A_m[i][k] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < KMAX; k++)
            for (int j = 0; j < COLS; j++) B_m[k][j] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready0),  64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid0), 64'd0);
        chk({tag, "_busy"},      64'(busy0),      64'd0);
        chk({tag, "_done"},      64'(done0),      64'd0);
        chk({tag, "_out_row"},   out_row0,        64'd0);
        chk({tag, "_busy_sat"},  64'(busy1),      64'd0);
    endtask

    task automatic start_job(input int k);
        k_len = 8'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy0), 64'd1);
        if (k == 0) begin
            chk("k0_in_ready", 64'(in_ready0), 64'd0);
            chk("k0_out_valid", 64'(out_valid0), 64'd1);
        end
    endtask

    task automatic feed(input int k, input bit toggle, input bit poke);
        int beat = 0;
        int cyc  = 0;
        bit acc;
        while (beat < k && cyc < 200) begin
            in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (in_valid) begin
                for (int i = 0; i < ROWS; i++) a_vec[i*DW +: DW] = 8'(A_m[i][beat]);
                for (int j = 0; j < COLS; j++) b_vec[j*DW +: DW] = 8'(B_m[beat][j]);
            end else begin
                a_vec = $urandom;
                b_vec = $urandom;
            end
            start = poke && (cyc == 1);
            k_len = 8'd7;
            chk("feed_in_ready", 64'(in_ready0), 64'd1);
            acc = in_valid && in_ready0;
            @(posedge clk); #1;
            if (acc) beat++;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        a_vec    = $urandom;
        b_vec    = $urandom;
        chk("feed_beats", 64'(beat), 64'(k));
    endtask

    task automatic collect(input int k, input bit stall);
        int e   = 0;
        int cyc = 0;
        bit hs;
        while (e < ROWS && cyc < 300) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = 1'b0;
            if (out_valid0) begin
                chk("out_idx",      64'(out_idx0),   64'(e));
                chk("out_row",      out_row0,        exp_row(e, k, 1'b0));
                chk("out_row_sat",  out_row1,        exp_row(e, k, 1'b1));
                chk("out_in_ready", 64'(in_ready0),  64'd0);
                chk("sat_in_step",  64'(out_valid1), 64'd1);
                hs = out_ready;
            end
            @(posedge clk); #1;
            if (hs) e++;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("rows_read",     64'(e),          64'(ROWS));
        chk("done_pulse",    64'(done0),      64'd1);
        chk("done_pulse_sat",64'(done1),      64'd1);
        chk("busy_dropped",  64'(busy0),      64'd0);
        chk("out_valid_end", 64'(out_valid0), 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done0), 64'd0);
    endtask

    task automatic job(input int k, input bit toggle, input bit stall, input bit poke);
        start_job(k);
        feed(k, toggle, poke);
        collect(k, stall);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_vec = '0; b_vec = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_quiet("idle");

        // Identity A, B[k][j] = 4k+j+1: rows read back equal B.
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < KMAX; k++) A_m[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < KMAX; k++)
            for (int j = 0; j < COLS; j++) B_m[k][j] = k * 4 + j + 1;
        job(4, 1'b0, 1'b0, 1'b0);

        // Random K=3 with gappy input and stalled output.
        fill_random();
        job(3, 1'b1, 1'b1, 1'b0);

        // Extreme signed operands: wrap vs saturate.
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < KMAX; k++) A_m[i][k] = -128;
        for (int k = 0; k < KMAX; k++)
            for (int j = 0; j < COLS; j++) B_m[k][j] = 127;
        job(4, 1'b0, 1'b0, 1'b0);

        // Empty job.
        fill_random();
        job(0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of DRAIN.
        fill_random();
        start_job(4);
        feed(4, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 64'(done0), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_quiet("post_abort");
        fill_random();
        job(2, 1'b0, 1'b0, 1'b0);

        // Stray start while busy, then back-to-back jobs of different K.
        fill_random();
        job(5, 1'b1, 1'b1, 1'b1);
        fill_random();
        job(2, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
